// File: rtl/dfi_phy_ctrl_responder.sv
// rtl/dfi_phy_ctrl_responder.sv - PHY-side responder for DFI init, ctrlupd and phyupd handshakes
//
// Ports:
//   core_clk, core_arstn       clock and asynchronous active-low reset
//   dfi_init_start (in)        controller init request
//   dfi_freq_ratio (in, 2)     must be 2'b11 for init to complete
//   dfi_init_complete (out)    PHY initialised
//   dfi_ctrlupd_req/ack        controller-initiated update handshake
//   dfi_phyupd_req/type (out)  PHY-initiated update request and its latched type
//   dfi_phyupd_ack (in)        controller grant for the PHY update
//   phy_lock (in)              PLL/DLL locked
//   phy_upd_need/type (in)     calibration logic wants an update of this type
//   phy_upd_go (out)           PHY update window open
//   ctrl_upd_go (out)          mirrors dfi_ctrlupd_ack
//   phyupd_timeout (out)       sticky ack-timeout flag, cleared only by reset
module dfi_phy_ctrl_responder #(
  parameter int T_INIT        = 64,
  parameter int T_CTRLUPD_ACK = 2,
  parameter int T_PHYUPD_RESP = 256,
  parameter int T_PHYUPD_HOLD = 16
) (
  input  logic       core_clk,
  input  logic       core_arstn,
  input  logic       dfi_init_start,
  input  logic [1:0] dfi_freq_ratio,
  output logic       dfi_init_complete,
  input  logic       dfi_ctrlupd_req,
  output logic       dfi_ctrlupd_ack,
  output logic       dfi_phyupd_req,
  output logic [1:0] dfi_phyupd_type,
  input  logic       dfi_phyupd_ack,
  input  logic       phy_lock,
  input  logic       phy_upd_need,
  input  logic [1:0] phy_upd_type,
  output logic       phy_upd_go,
  output logic       ctrl_upd_go,
  output logic       phyupd_timeout
);

  localparam int TMAX_A = (T_INIT > T_CTRLUPD_ACK) ? T_INIT : T_CTRLUPD_ACK;
  localparam int TMAX_B = (T_PHYUPD_RESP > T_PHYUPD_HOLD) ? T_PHYUPD_RESP : T_PHYUPD_HOLD;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int CW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    WAIT_START,
    INIT_CNT,
    READY,
    CTRLUPD,
    PHYUPD_REQ,
    PHYUPD_ACT,
    PHYUPD_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          init_complete_nxt;
  logic          ctrlupd_ack_nxt;
  logic          phyupd_req_nxt;
  logic [1:0]    phyupd_type_nxt;
  logic          phy_go_nxt;
  logic          ctrl_go_nxt;
  logic          timeout_nxt;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state             <= WAIT_START;
      cnt               <= '0;
      dfi_init_complete <= 1'b0;
      dfi_ctrlupd_ack   <= 1'b0;
      dfi_phyupd_req    <= 1'b0;
      dfi_phyupd_type   <= 2'b00;
      phy_upd_go        <= 1'b0;
      ctrl_upd_go       <= 1'b0;
      phyupd_timeout    <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      dfi_init_complete <= init_complete_nxt;
      dfi_ctrlupd_ack   <= ctrlupd_ack_nxt;
      dfi_phyupd_req    <= phyupd_req_nxt;
      dfi_phyupd_type   <= phyupd_type_nxt;
      phy_upd_go        <= phy_go_nxt;
      ctrl_upd_go       <= ctrl_go_nxt;
      phyupd_timeout    <= timeout_nxt;
    end
  end

  // Counts that end "N cycles after the sampling edge" load N-1 and fire on
  // the edge that sees zero. The phyupd counts load N because their first
  // edge is spent raising the output one cycle after the triggering sample.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    init_complete_nxt = dfi_init_complete;
    ctrlupd_ack_nxt   = dfi_ctrlupd_ack;
    phyupd_req_nxt    = dfi_phyupd_req;
    phyupd_type_nxt   = dfi_phyupd_type;
    phy_go_nxt        = phy_upd_go;
    ctrl_go_nxt       = ctrl_upd_go;
    timeout_nxt       = phyupd_timeout;

    if (state != WAIT_START && state != INIT_CNT && !phy_lock) begin
      // Lock loss drops everything except the sticky timeout.
      state_nxt         = WAIT_START;
      cnt_nxt           = '0;
      init_complete_nxt = 1'b0;
      ctrlupd_ack_nxt   = 1'b0;
      phyupd_req_nxt    = 1'b0;
      phyupd_type_nxt   = 2'b00;
      phy_go_nxt        = 1'b0;
      ctrl_go_nxt       = 1'b0;
    end else begin
      case (state)
        WAIT_START: begin
          if (dfi_init_start) begin
            state_nxt = INIT_CNT;
            cnt_nxt   = CW'(T_INIT - 1);
          end
        end
        INIT_CNT: begin
          if (!dfi_init_start) begin
            state_nxt = WAIT_START;
            cnt_nxt   = '0;
          end else if (cnt == '0) begin
            if (phy_lock && dfi_freq_ratio == 2'b11) begin
              state_nxt         = READY;
              init_complete_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        READY: begin
          if (dfi_ctrlupd_req) begin
            state_nxt = CTRLUPD;
            cnt_nxt   = CW'(T_CTRLUPD_ACK - 1);
          end else if (phy_upd_need) begin
            state_nxt       = PHYUPD_REQ;
            cnt_nxt         = CW'(T_PHYUPD_RESP);
            phyupd_type_nxt = phy_upd_type;
          end
        end
        CTRLUPD: begin
          if (!dfi_ctrlupd_req) begin
            state_nxt       = READY;
            cnt_nxt         = '0;
            ctrlupd_ack_nxt = 1'b0;
            ctrl_go_nxt     = 1'b0;
          end else if (cnt == '0) begin
            ctrlupd_ack_nxt = 1'b1;
            ctrl_go_nxt     = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        PHYUPD_REQ: begin
          // Ack is only honoured once req is visible to the controller.
          if (!dfi_phyupd_req) begin
            phyupd_req_nxt = 1'b1;
            cnt_nxt        = cnt - CW'(1);
          end else if (dfi_phyupd_ack) begin
            state_nxt = PHYUPD_ACT;
            cnt_nxt   = CW'(T_PHYUPD_HOLD);
          end else if (cnt == '0) begin
            state_nxt      = PHYUPD_DONE;
            phyupd_req_nxt = 1'b0;
            timeout_nxt    = 1'b1;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        PHYUPD_ACT: begin
          if (cnt == '0) begin
            state_nxt      = PHYUPD_DONE;
            phyupd_req_nxt = 1'b0;
            phy_go_nxt     = 1'b0;
          end else begin
            phy_go_nxt = 1'b1;
            cnt_nxt    = cnt - CW'(1);
          end
        end
        PHYUPD_DONE: begin
          if (!dfi_phyupd_ack) begin
            state_nxt = READY;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = WAIT_START;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfi_phy_ctrl_responder.sv
// tb/tb_dfi_phy_ctrl_responder.sv - self-checking bench for dfi_phy_ctrl_responder
module tb_dfi_phy_ctrl_responder;

  localparam int T_INIT = 64;
  localparam int T_CA   = 2;
  localparam int T_RESP = 256;
  localparam int T_HOLD = 16;

  logic       core_clk = 1'b0;
  logic       core_arstn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] ratio = 2'b11;
  logic       creq = 1'b0;
  logic       pack = 1'b0;
  logic       lock = 1'b1;
  logic       need = 1'b0;
  logic [1:0] ptype = 2'b00;

  logic       comp, cack, preq, pgo, cgo, pto;
  logic [1:0] ptype_o;

  dfi_phy_ctrl_responder #(
    .T_INIT(T_INIT), .T_CTRLUPD_ACK(T_CA), .T_PHYUPD_RESP(T_RESP), .T_PHYUPD_HOLD(T_HOLD)
  ) dut (
    .core_clk(core_clk),
    .core_arstn(core_arstn),
    .dfi_init_start(start),
    .dfi_freq_ratio(ratio),
    .dfi_init_complete(comp),
    .dfi_ctrlupd_req(creq),
    .dfi_ctrlupd_ack(cack),
    .dfi_phyupd_req(preq),
    .dfi_phyupd_type(ptype_o),
    .dfi_phyupd_ack(pack),
    .phy_lock(lock),
    .phy_upd_need(need),
    .phy_upd_type(ptype),
    .phy_upd_go(pgo),
    .ctrl_upd_go(cgo),
    .phyupd_timeout(pto)
  );

  always #5 core_clk = ~core_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic       e_comp, e_ack, e_preq, e_pgo, e_to;
  logic [1:0] e_type;

  int b, len, n0, rr, aa, gg, xx, dd, to, n2, r2, a2, g2, c, ll, s, r, e, fin;
  logic [1:0] t, t2;
  int lens [8];

  // After step(), cyc is the index of the edge just taken; inputs set now are
  // sampled on edge cyc+1.
  task automatic step();
    @(posedge core_clk);
    #1;
    cyc++;
  endtask

  function automatic logic win(input int x, input int lo, input int hi);
    return (x >= lo) && (x < hi);
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".init_complete"}, {1'b0, comp}, {1'b0, e_comp});
    chk({tag, ".ctrlupd_ack"}, {1'b0, cack}, {1'b0, e_ack});
    chk({tag, ".ctrl_upd_go"}, {1'b0, cgo}, {1'b0, e_ack});
    chk({tag, ".phyupd_req"}, {1'b0, preq}, {1'b0, e_preq});
    chk({tag, ".phy_upd_go"}, {1'b0, pgo}, {1'b0, e_pgo});
    chk({tag, ".phyupd_type"}, ptype_o, e_type);
    chk({tag, ".timeout"}, {1'b0, pto}, {1'b0, e_to});
  endtask

  task automatic do_reset();
    core_arstn = 1'b0;
    start = 1'b0; ratio = 2'b11; creq = 1'b0; pack = 1'b0;
    lock = 1'b1; need = 1'b0; ptype = 2'b00;
    repeat (3) step();
    e_comp = 0; e_ack = 0; e_preq = 0; e_pgo = 0; e_to = 0; e_type = 2'b00;
    chk_all("reset");
    cyc = 0;
    core_arstn = 1'b1;
  endtask

  initial begin
    // Init: start sampled from edge 10, complete from edge 10+T_INIT.
    do_reset();
    while (cyc < 96) begin
      start = (cyc + 1 >= 10);
      step();
      e_comp = (cyc >= 10 + T_INIT);
      chk_all("init");
    end

    // Controller updates: directed lengths then random ones.
    lens[0] = 21; lens[1] = 1; lens[2] = 2; lens[3] = 3;
    for (int i = 4; i < 8; i++) lens[i] = $urandom_range(1, 25);
    for (int i = 0; i < 8; i++) begin
      len = lens[i];
      b = cyc + 4;
      while (cyc < b + len + 2) begin
        creq = win(cyc + 1, b, b + len);
        step();
        e_ack = win(cyc, b + T_CA, b + len);
        chk_all("ctrlupd");
      end
    end

    // PHY updates granted after a delay; type noise outside the request edge.
    for (int i = 0; i < 5; i++) begin
      dd = (i == 0) ? 4 : $urandom_range(1, 10);
      t = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      xx = $urandom_range(0, 3);
      n0 = cyc + 3; rr = n0 + 1; aa = rr + dd; gg = aa + 1 + T_HOLD;
      while (cyc < gg + xx + 3) begin
        e = cyc + 1;
        need = (e == n0);
        ptype = (e == n0) ? t : 2'($urandom);
        pack = win(e, aa, gg + xx);
        step();
        if (cyc == n0) e_type = t;
        e_preq = win(cyc, rr, gg);
        e_pgo = win(cyc, aa + 1, gg);
        chk_all("phyupd");
      end
    end

    // Timeout, then need still high gives a fresh request after one READY cycle.
    t = 2'b01; t2 = 2'b11;
    n0 = cyc + 3; rr = n0 + 1; to = rr + T_RESP;
    n2 = to + 2; r2 = to + 3; a2 = r2 + 2; g2 = a2 + 1 + T_HOLD;
    while (cyc < g2 + 3) begin
      e = cyc + 1;
      need = win(e, n0, n2 + 1);
      ptype = (e == n0) ? t : ((e == n2) ? t2 : 2'($urandom));
      pack = win(e, a2, g2);
      step();
      if (cyc == n0) e_type = t;
      if (cyc == n2) e_type = t2;
      if (cyc >= to) e_to = 1'b1;
      e_preq = win(cyc, rr, to) | win(cyc, r2, g2);
      e_pgo = win(cyc, a2 + 1, g2);
      chk_all("timeout");
    end

    // Collision: ctrlupd wins; ctrlupd during the PHY window waits for READY.
    c = cyc + 3; rr = c + 8; aa = rr + 2; gg = aa + 1 + T_HOLD;
    t = 2'($urandom_range(0, 3));
    while (cyc < gg + 10) begin
      e = cyc + 1;
      creq = win(e, c, c + 6) | win(e, aa + 3, gg + 8);
      need = win(e, c, c + 8);
      ptype = (e == c + 7) ? t : 2'($urandom);
      pack = win(e, aa, gg);
      step();
      if (cyc == c + 7) e_type = t;
      e_ack = win(cyc, c + T_CA, c + 6) | win(cyc, gg + 2 + T_CA, gg + 8);
      e_preq = win(cyc, rr, gg);
      e_pgo = win(cyc, aa + 1, gg);
      chk_all("collision");
    end

    // Lock loss in the PHY window clears all but timeout; re-init needs start.
    t = 2'($urandom_range(0, 3));
    n0 = cyc + 3; rr = n0 + 1; aa = rr + 1; ll = aa + 4;
    while (cyc < ll + 10) begin
      e = cyc + 1;
      need = (e == n0);
      ptype = (e == n0) ? t : 2'($urandom);
      pack = win(e, aa, ll + 2);
      lock = !win(e, ll, ll + 5);
      start = (e < ll);
      step();
      if (cyc == n0) e_type = t;
      if (cyc == ll) e_type = 2'b00;
      e_comp = (cyc < ll);
      e_preq = win(cyc, rr, ll);
      e_pgo = win(cyc, aa + 1, ll);
      chk_all("lockloss");
    end
    s = cyc + 3;
    while (cyc < s + T_INIT + 3) begin
      start = (cyc + 1 >= s);
      step();
      e_comp = (cyc >= s + T_INIT);
      chk_all("reinit");
    end

    // Asynchronous reset while ack is high clears outputs before any edge.
    b = cyc + 3;
    while (cyc < b + T_CA + 1) begin
      creq = win(cyc + 1, b, b + 10);
      step();
      e_ack = win(cyc, b + T_CA, b + 10);
      chk_all("ctrl_pre_reset");
    end
    #2 core_arstn = 1'b0;
    #1;
    e_comp = 0; e_ack = 0; e_to = 0; e_type = 2'b00;
    chk_all("async_reset");
    do_reset();

    // Wrong ratio: count reaches zero and holds; ratio fixed completes next edge.
    ratio = 2'b01;
    fin = 5 + T_INIT + 20;
    while (cyc < fin) begin
      start = (cyc + 1 >= 5);
      step();
      chk_all("ratio_bad");
    end
    r = cyc + 3;
    while (cyc < r + 3) begin
      ratio = (cyc + 1 >= r) ? 2'b11 : 2'b01;
      step();
      e_comp = (cyc >= r);
      chk_all("ratio_fix");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
